// File: rtl/cbfp_pkg.sv
// Shared CBFP constants and types used by the stage-0 normaliser and its
// downstream frame serializer.
package cbfp_pkg;

    localparam int CBFP_N     = 512;
    localparam int CBFP_BW    = 11;
    localparam int CBFP_IDX_W = 5;
    localparam int CBFP_NPAR  = 16;
    localparam int CBFP_BEATS = CBFP_N / CBFP_NPAR;

    typedef enum logic {IDLE, STREAM} ser_state_t;

    typedef logic signed [CBFP_BW-1:0] cbfp_sample_t;
    typedef logic [CBFP_IDX_W-1:0]     cbfp_index_t;

endpackage

// File: rtl/cbfp_frame_serializer.sv
// Captures one normalised CBFP frame in a single cycle and streams it out as
// NPAR-sample beats over valid/ready; frames arriving while busy are dropped.
module cbfp_frame_serializer
    import cbfp_pkg::*;
#(
    parameter int N     = CBFP_N,
    parameter int BW    = CBFP_BW,
    parameter int IDX_W = CBFP_IDX_W,
    parameter int NPAR  = CBFP_NPAR
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          in_valid,
    input  logic signed [BW-1:0]          real_in  [0:N-1],
    input  logic signed [BW-1:0]          imag_in  [0:N-1],
    input  logic [IDX_W-1:0]              index_in [0:N-1],
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [BW-1:0]          real_out  [0:NPAR-1],
    output logic signed [BW-1:0]          imag_out  [0:NPAR-1],
    output logic [IDX_W-1:0]              index_out [0:NPAR-1],
    output logic [$clog2(N/NPAR)-1:0]     out_beat,
    output logic                          out_last,
    output logic                          busy,
    output logic                          drop
);

    localparam int BEATS  = N / NPAR;
    localparam int BEAT_W = $clog2(BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    ser_state_t        state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              last_q, last_d;
    logic              drop_q, drop_d;
    logic              capture;

    // Frame register stored beat-major so the output mux indexes by beat directly
    logic signed [BW-1:0] real_q [0:BEATS-1][0:NPAR-1];
    logic signed [BW-1:0] imag_q [0:BEATS-1][0:NPAR-1];
    logic [IDX_W-1:0]     idx_q  [0:BEATS-1][0:NPAR-1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            beat_q  <= '0;
            last_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            last_q  <= last_d;
            drop_q  <= drop_d;
        end
    end

    // A capture is allowed from IDLE or on the final handshake (back-to-back);
    // any other in_valid while streaming is reported and discarded.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        last_d  = last_q;
        drop_d  = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    capture = 1'b1;
                    beat_d  = '0;
                    last_d  = 1'b0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d = '0;
                        last_d = 1'b0;
                        if (in_valid) begin
                            capture = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                        last_d = (beat_q == LAST_BEAT - 1'b1);
                    end
                end
                if (in_valid && !(out_ready && beat_q == LAST_BEAT)) begin
                    drop_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int b = 0; b < BEATS; b++) begin
                for (int j = 0; j < NPAR; j++) begin
                    real_q[b][j] <= '0;
                    imag_q[b][j] <= '0;
                    idx_q[b][j]  <= '0;
                end
            end
        end else if (capture) begin
            for (int b = 0; b < BEATS; b++) begin
                for (int j = 0; j < NPAR; j++) begin
                    real_q[b][j] <= real_in[b*NPAR + j];
                    imag_q[b][j] <= imag_in[b*NPAR + j];
                    idx_q[b][j]  <= index_in[b*NPAR + j];
                end
            end
        end
    end

    // Output data is a pure register mux; nothing from the *_in ports reaches it.
    for (genvar j = 0; j < NPAR; j++) begin : g_out
        assign real_out[j]  = real_q[beat_q][j];
        assign imag_out[j]  = imag_q[beat_q][j];
        assign index_out[j] = idx_q[beat_q][j];
    end

    assign out_valid = (state_q == STREAM);
    assign busy      = (state_q == STREAM);
    assign out_beat  = beat_q;
    assign out_last  = last_q;
    assign drop      = drop_q;

endmodule

// File: tb/tb_cbfp_frame_serializer.sv
// Scoreboard bench for cbfp_frame_serializer: stimulus pushes expected beats,
// a negedge monitor pops and compares every accepted beat and every stall.
module tb_cbfp_frame_serializer;
    import cbfp_pkg::*;

    localparam int N     = 512;
    localparam int NPAR  = 16;
    localparam int BEATS = 32;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic signed [10:0] real_in  [0:N-1];
    logic signed [10:0] imag_in  [0:N-1];
    logic [4:0]         index_in [0:N-1];
    logic               out_valid, out_last, busy, drop;
    logic signed [10:0] real_out  [0:NPAR-1];
    logic signed [10:0] imag_out  [0:NPAR-1];
    logic [4:0]         index_out [0:NPAR-1];
    logic [4:0]         out_beat;

    always #5 clk = ~clk;

    cbfp_frame_serializer dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .real_in   (real_in),
        .imag_in   (imag_in),
        .index_in  (index_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .real_out  (real_out),
        .imag_out  (imag_out),
        .index_out (index_out),
        .out_beat  (out_beat),
        .out_last  (out_last),
        .busy      (busy),
        .drop      (drop)
    );

    typedef struct packed {
        logic [1:0]          tag;
        logic [4:0]          beat;
        logic                last;
        logic [NPAR*11-1:0]  r;
        logic [NPAR*11-1:0]  i;
        logic [NPAR*5-1:0]   x;
    } beat_t;

    beat_t exp_q[$];
    int vectors = 0;
    int miscompares = 0;
    int drop_cnt = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // kind 0: ramp, 1: full-scale constant, 2: overrun intruder
    task automatic load_frame(input int kind);
        for (int k = 0; k < N; k++) begin
            case (kind)
                0: begin
                    real_in[k]  = 11'(k % 1024);
                    imag_in[k]  = 11'(-k);
                    index_in[k] = 5'(k / 64);
                end
                1: begin
                    real_in[k]  = 11'sd1023;
                    imag_in[k]  = -11'sd1024;
                    index_in[k] = 5'd31;
                end
                default: begin
                    real_in[k]  = 11'(500 - k);
                    imag_in[k]  = 11'(k);
                    index_in[k] = 5'(31 - k / 32);
                end
            endcase
        end
    endtask

    task automatic push_frame(input int kind);
        beat_t e;
        for (int b = 0; b < BEATS; b++) begin
            e.tag  = 2'(kind);
            e.beat = 5'(b);
            e.last = (b == BEATS - 1);
            for (int j = 0; j < NPAR; j++) begin
                e.r[j*11 +: 11] = real_in[b*NPAR + j];
                e.i[j*11 +: 11] = imag_in[b*NPAR + j];
                e.x[j*5 +: 5]   = index_in[b*NPAR + j];
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_beat(input logic [4:0] b, input string name);
        int n = 0;
        while (!(out_valid && out_beat == b) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: beat %0d never presented (timeout)", name, b);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: busy never cleared (timeout)", name);
        end
    endtask

    // Monitor: checks held outputs on stalls and pops the scoreboard on handshakes
    beat_t c, held, e, hand;
    bit prev_stall = 1'b0;

    always @(negedge clk) begin
        if (!rstn) begin
            prev_stall = 1'b0;
        end else begin
            c.tag  = 2'd0;
            c.beat = out_beat;
            c.last = out_last;
            for (int j = 0; j < NPAR; j++) begin
                c.r[j*11 +: 11] = real_out[j];
                c.i[j*11 +: 11] = imag_out[j];
                c.x[j*5 +: 5]   = index_out[j];
            end
            if (prev_stall) begin
                check("stall_valid", 256'(out_valid), 256'(1));
                check("stall_real", 256'(c.r), 256'(held.r));
                check("stall_imag", 256'(c.i), 256'(held.i));
                check("stall_idx_beat_last", 256'({c.x, c.beat, c.last}),
                      256'({held.x, held.beat, held.last}));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_beat: got beat %0d, expected no beat", out_beat);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_num", 256'(c.beat), 256'(e.beat));
                    check("beat_last", 256'(c.last), 256'(e.last));
                    check("beat_real", 256'(c.r), 256'(e.r));
                    check("beat_imag", 256'(c.i), 256'(e.i));
                    check("beat_index", 256'(c.x), 256'(e.x));
                    if (e.tag == 2'd0 && e.beat == 5'd3) begin
                        for (int j = 0; j < NPAR; j++) begin
                            hand.r[j*11 +: 11] = 11'(48 + j);
                            hand.i[j*11 +: 11] = 11'(-(48 + j));
                            hand.x[j*5 +: 5]   = 5'd0;
                        end
                        check("ramp_beat3_real", 256'(c.r), 256'(hand.r));
                        check("ramp_beat3_imag", 256'(c.i), 256'(hand.i));
                        check("ramp_beat3_index", 256'(c.x), 256'(hand.x));
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            held = c;
            if (drop) drop_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int hi_cnt;
        int n;

        // Reset values
        out_ready = 1'b1;
        load_frame(0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_drop", 256'(drop), 256'(0));
        check("rst_last_beat", 256'({out_last, out_beat}), 256'(0));
        check("rst_data", 256'({real_out[0], imag_out[0], index_out[0]}), 256'(0));
        rstn = 1'b1;
        tick();
        check("idle_no_valid", 256'(out_valid), 256'(0));

        // Ramp frame, out_ready held high
        push_frame(0);
        pulse();
        check("ramp_first_valid", 256'(out_valid), 256'(1));
        check("ramp_first_beat", 256'({out_beat, out_last, busy}), 256'({5'd0, 1'b0, 1'b1}));
        wait_idle("ramp");
        check("ramp_end_valid", 256'({out_valid, out_last}), 256'(0));
        check("ramp_queue_empty", 256'(exp_q.size()), 256'(0));
        check("ramp_no_drop", 256'(drop_cnt), 256'(0));

        // Backpressure with a random 50% ready pattern
        push_frame(0);
        pulse();
        n = 0;
        while (busy && n < 400) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        out_ready = 1'b1;
        check("bp_finished", 256'(busy), 256'(0));
        check("bp_queue_empty", 256'(exp_q.size()), 256'(0));

        // Back-to-back: second frame on the beat-31 handshake
        push_frame(0);
        pulse();
        wait_beat(5'd31, "b2b_wait31");
        load_frame(1);
        push_frame(1);
        base = drop_cnt;
        pulse();
        check("b2b_valid_held", 256'(out_valid), 256'(1));
        check("b2b_beat0", 256'({out_beat, out_last}), 256'(0));
        check("b2b_drop_now", 256'(drop), 256'(0));
        wait_idle("b2b");
        check("b2b_drop_total", 256'(drop_cnt - base), 256'(0));
        check("b2b_queue_empty", 256'(exp_q.size()), 256'(0));

        // Overrun at beat 10
        load_frame(0);
        push_frame(0);
        pulse();
        wait_beat(5'd10, "ovr_wait10");
        load_frame(2);
        base = drop_cnt;
        pulse();
        check("ovr_drop_high", 256'(drop), 256'(1));
        check("ovr_beat_advance", 256'({out_beat, busy}), 256'({5'd11, 1'b1}));
        tick();
        check("ovr_drop_low", 256'(drop), 256'(0));
        wait_idle("ovr");
        check("ovr_drop_total", 256'(drop_cnt - base), 256'(1));
        check("ovr_idle", 256'(out_valid), 256'(0));
        check("ovr_queue_empty", 256'(exp_q.size()), 256'(0));

        // Asynchronous reset at beat 17
        load_frame(0);
        push_frame(0);
        pulse();
        wait_beat(5'd17, "rst_wait17");
        #1;
        rstn = 1'b0;
        #1;
        check("arst_ctrl", 256'({out_valid, busy, out_last, drop, out_beat}), 256'(0));
        check("arst_data", 256'({real_out[0], imag_out[5], index_out[15]}), 256'(0));
        exp_q.delete();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        hi_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (out_valid) hi_cnt++;
        end
        check("arst_wait_idle", 256'(hi_cnt), 256'(0));
        load_frame(1);
        push_frame(1);
        pulse();
        check("arst_new_frame_beat0", 256'({out_valid, out_beat}), 256'({1'b1, 5'd0}));
        check("arst_new_frame_real0", 256'(11'(real_out[0])), 256'(11'sd1023));
        wait_idle("arst_new_frame");
        check("arst_queue_empty", 256'(exp_q.size()), 256'(0));

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
